// File: rtl/led_frame_pkg.sv
// Shared constants for the double-buffered LED frame store.
// Defaults, read latency and swap counter width live here.
package led_frame_pkg;
  localparam int RD_LATENCY    = 2;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 9;
  localparam int DEF_NUM_WORDS = 512;
  localparam int SWAP_W        = 8;

  typedef logic [SWAP_W-1:0] swap_cnt_t;
endpackage

// File: rtl/led_frame_ram_if.sv
// Writer/reader bundle of the LED frame store.
// master drives writes, reads and commits; slave is the store.
interface led_frame_ram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  import led_frame_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W/8-1:0] wr_be;
  logic              commit;
  logic              commit_pending;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_frame_start;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              front_bank;
  logic              wr_err;
  swap_cnt_t         swap_count;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be,
    output commit, rd_en, rd_addr,
    output rd_frame_start,
    input  commit_pending, rd_data,
    input  rd_valid, front_bank,
    input  wr_err, swap_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be,
    input  commit, rd_en, rd_addr,
    input  rd_frame_start,
    output commit_pending, rd_data,
    output rd_valid, front_bank,
    output wr_err, swap_count
  );
endinterface

// File: rtl/sdp_ram_core.sv
// Simple dual-port RAM: byte-enabled write port,
// registered read port, no reset on storage or output.
module sdp_ram_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (wbe[i]) begin
          mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/led_frame_ram.sv
// Double-buffered LED frame store: writer fills the back bank,
// reader scans the front bank, swap only at a frame boundary.
module led_frame_ram
  import led_frame_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input logic            clock,
  input logic            reset,
  led_frame_ram_if.slave bus
);
  localparam int PA_W = ADDR_W + 1;
  localparam logic [PA_W-1:0] NW =
    PA_W'(NUM_WORDS);

  logic front_q, front_d;
  logic pend_q, pend_d;
  logic err_q, err_d;
  logic oor_q, oor_d;
  swap_cnt_t cnt_q, cnt_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic [DATA_W-1:0] ram_q;

  logic wr_in, rd_in, swap;
  logic we, re;
  logic [PA_W-1:0] waddr, raddr;

  function automatic logic [PA_W-1:0] phys(
    input logic              bank,
    input logic [ADDR_W-1:0] a
  );
    return {1'b0, a} + (bank ? NW : '0);
  endfunction

  // Read and write always target opposite banks
  // in the same cycle, so the RAM never collides.
  always_comb begin
    wr_in = {1'b0, bus.wr_addr} < NW;
    rd_in = {1'b0, bus.rd_addr} < NW;
    we    = ~reset & bus.wr_en & wr_in;
    re    = ~reset & bus.rd_en & rd_in;
    waddr = phys(~front_q, bus.wr_addr);
    raddr = phys(front_q, bus.rd_addr);
    swap  = (pend_q | bus.commit) &
            bus.rd_frame_start;
    front_d = front_q ^ swap;
    pend_d  = (pend_q | bus.commit) & ~swap;
    cnt_d   = cnt_q + SWAP_W'(swap);
    err_d   = err_q | (bus.wr_en & ~wr_in);
    vld_d   = {vld_q[RD_LATENCY-2:0], bus.rd_en};
    oor_d   = ~rd_in;
    rdat_d  = rdat_q;
    if (vld_q[0]) begin
      rdat_d = oor_q ? '0 : ram_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      front_q <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      oor_q   <= 1'b0;
      cnt_q   <= '0;
      vld_q   <= '0;
      rdat_q  <= '0;
    end else begin
      front_q <= front_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      oor_q   <= oor_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      rdat_q  <= rdat_d;
    end
  end

  sdp_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (PA_W),
    .DEPTH  (2 * NUM_WORDS)
  ) u_ram (
    .clk   (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.wr_data),
    .wbe   (bus.wr_be),
    .re    (re),
    .raddr (raddr),
    .rdata (ram_q)
  );

  assign bus.commit_pending = pend_q;
  assign bus.front_bank     = front_q;
  assign bus.wr_err         = err_q;
  assign bus.swap_count     = cnt_q;
  assign bus.rd_valid       = vld_q[RD_LATENCY-1];
  assign bus.rd_data        = rdat_q;
endmodule

// File: tb/tb_led_frame_ram.sv
// Randomized bench for led_frame_ram against a bank-array model,
// with directed scenarios pinning the model to literal values.
module tb_led_frame_ram;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int NW = 384;
  localparam int BW = DW / 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  led_frame_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  led_frame_ram #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  function automatic void cmp(input string n,
                              input logic [31:0] a,
                              input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t",
               n, a, e, $time);
    end
  endfunction

  // Model: two banks as one flat array; reads capture their
  // word at issue time and surface two clock edges later.
  logic [DW-1:0] m_mem [2*NW];
  int m_front, m_pend, m_err, m_cnt;
  int p1_v, out_v;
  logic [DW-1:0] p1_d, out_d;

  always @(posedge clock) begin
    if (reset) begin
      m_front = 0; m_pend = 0; m_err = 0; m_cnt = 0;
      p1_v = 0; out_v = 0; out_d = '0;
    end else begin
      out_v = p1_v;
      if (p1_v != 0) out_d = p1_d;
      p1_v = bus.rd_en ? 1 : 0;
      if (bus.rd_en) begin
        if (int'(bus.rd_addr) >= NW) p1_d = '0;
        else p1_d = m_mem[m_front*NW + int'(bus.rd_addr)];
      end
      if (bus.wr_en) begin
        if (int'(bus.wr_addr) >= NW) m_err = 1;
        else begin
          for (int i = 0; i < BW; i++)
            if (bus.wr_be[i])
              m_mem[(1-m_front)*NW + int'(bus.wr_addr)][i*8 +: 8]
                = bus.wr_data[i*8 +: 8];
        end
      end
      if ((m_pend != 0 || bus.commit) && bus.rd_frame_start) begin
        m_front = 1 - m_front;
        m_pend = 0;
        m_cnt = (m_cnt + 1) % 256;
      end else if (bus.commit) begin
        m_pend = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      cmp("rd_valid", 32'(bus.rd_valid), 32'(out_v));
      cmp("rd_data", bus.rd_data, out_d);
      cmp("front_bank", 32'(bus.front_bank), 32'(m_front));
      cmp("commit_pending", 32'(bus.commit_pending), 32'(m_pend));
      cmp("wr_err", 32'(bus.wr_err), 32'(m_err));
      cmp("swap_count", 32'(bus.swap_count), 32'(m_cnt));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic idle();
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.wr_be = '0; bus.commit = 0; bus.rd_en = 0;
    bus.rd_addr = '0; bus.rd_frame_start = 0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d,
                    input logic [BW-1:0] be);
    bus.wr_en = 1; bus.wr_addr = AW'(a);
    bus.wr_data = d; bus.wr_be = be;
    tick();
    bus.wr_en = 0;
  endtask

  task automatic swap_now();
    bus.commit = 1; bus.rd_frame_start = 1;
    tick();
    bus.commit = 0; bus.rd_frame_start = 0;
  endtask

  task automatic rd_chk(input string n, input int a,
                        input logic [DW-1:0] e);
    bus.rd_en = 1; bus.rd_addr = AW'(a);
    tick();
    bus.rd_en = 0;
    cmp({n, "_early"}, 32'(bus.rd_valid), 0);
    tick();
    cmp({n, "_valid"}, 32'(bus.rd_valid), 1);
    cmp({n, "_data"}, bus.rd_data, e);
  endtask

  initial begin
    reset = 1;
    idle();
    tick(2);
    chk_en = 1;
    cmp("rst_front", 32'(bus.front_bank), 0);
    cmp("rst_valid", 32'(bus.rd_valid), 0);
    cmp("rst_data", bus.rd_data, 0);
    cmp("rst_cnt", 32'(bus.swap_count), 0);
    reset = 0;

    for (int a = 0; a < NW; a++) wr(a, $urandom, '1);
    swap_now();
    for (int a = 0; a < NW; a++) wr(a, $urandom, '1);
    reset = 1; tick(); reset = 0;
    cmp("rst2_front", 32'(bus.front_bank), 0);

    wr(3, 32'hA5A5A5A5, '1);
    bus.commit = 1; tick(); bus.commit = 0;
    cmp("t40_pend", 32'(bus.commit_pending), 1);
    bus.rd_frame_start = 1; tick(); bus.rd_frame_start = 0;
    cmp("t40_front", 32'(bus.front_bank), 1);
    cmp("t40_cnt", 32'(bus.swap_count), 1);
    rd_chk("t40", 3, 32'hA5A5A5A5);

    wr(7, 32'h11223344, '1);
    wr(7, 32'hFFFFFFFF, 4'b0101);
    swap_now();
    cmp("t41_cnt", 32'(bus.swap_count), 2);
    rd_chk("t41", 7, 32'h11FF33FF);

    bus.commit = 1; tick(); bus.commit = 0;
    tick(100);
    cmp("t42_pend", 32'(bus.commit_pending), 1);
    cmp("t42_front", 32'(bus.front_bank), 0);
    bus.rd_frame_start = 1; tick(); bus.rd_frame_start = 0;
    cmp("t42_front2", 32'(bus.front_bank), 1);
    bus.rd_frame_start = 1; tick(5); bus.rd_frame_start = 0;
    cmp("t42_cnt", 32'(bus.swap_count), 3);

    wr(5, 32'h0BADF00D, '1);
    swap_now();
    wr(5, 32'h600DCAFE, '1);
    bus.commit = 1; tick(); bus.commit = 0;
    bus.rd_frame_start = 1; bus.rd_en = 1; bus.rd_addr = 5;
    tick();
    bus.rd_frame_start = 0;
    tick();
    bus.rd_en = 0;
    cmp("t43_old_v", 32'(bus.rd_valid), 1);
    cmp("t43_old_d", bus.rd_data, 32'h0BADF00D);
    tick();
    cmp("t43_new_v", 32'(bus.rd_valid), 1);
    cmp("t43_new_d", bus.rd_data, 32'h600DCAFE);
    cmp("t43_cnt", 32'(bus.swap_count), 5);
    cmp("t43_front", 32'(bus.front_bank), 1);

    wr(NW, 32'hDEADBEEF, '1);
    cmp("t44_err", 32'(bus.wr_err), 1);
    rd_chk("t44", NW, 32'h0);
    bus.rd_en = 1; bus.rd_addr = 0; tick(); bus.rd_en = 0;
    tick(3);
    cmp("t44_sticky", 32'(bus.wr_err), 1);

    bus.commit = 1; tick(); bus.commit = 0;
    bus.rd_en = 1; bus.rd_addr = 1; tick();
    bus.rd_addr = 2; reset = 1; tick();
    bus.rd_en = 0; reset = 0;
    cmp("t45_valid", 32'(bus.rd_valid), 0);
    cmp("t45_pend", 32'(bus.commit_pending), 0);
    cmp("t45_front", 32'(bus.front_bank), 0);
    cmp("t45_err", 32'(bus.wr_err), 0);
    cmp("t45_data", bus.rd_data, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("t45_flush", 32'(bus.rd_valid), 0);
    end

    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      bus.wr_en = 1'($urandom);
      bus.wr_addr = AW'($urandom_range(0, NW + 15));
      bus.wr_data = $urandom;
      bus.wr_be = BW'($urandom);
      bus.commit = ($urandom_range(0, 7) == 0);
      bus.rd_frame_start = ($urandom_range(0, 3) == 0);
      bus.rd_en = 1'($urandom);
      bus.rd_addr = AW'($urandom_range(0, NW + 15));
      tick();
    end
    reset = 0;
    idle();
    tick(4);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/led_frame_ram.md
LED_FRAME_RAM -- requirements
Module: led_frame_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 32: pixel word width, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 9: per-bank word address width.
REQ-003 SHALL have parameter NUM_WORDS, default 512: words per bank, at most 2**ADDR_W.
REQ-004 SHALL have port clock, input, 1: single clock for all logic.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port wr_en, input, 1: write strobe.
REQ-007 SHALL have port wr_addr, input, ADDR_W: write word address into back bank.
REQ-008 SHALL have port wr_data, input, DATA_W: write data.
REQ-009 SHALL have port wr_be, input, DATA_W/8: byte enables, bit i gates byte i.
REQ-010 SHALL have port commit, input, 1: writer requests back/front swap.
REQ-011 SHALL have port commit_pending, output, 1: swap requested, not yet taken.
REQ-012 SHALL have port rd_en, input, 1: read strobe.
REQ-013 SHALL have port rd_addr, input, ADDR_W: read word address into front bank.
REQ-014 SHALL have port rd_frame_start, input, 1: reader at frame boundary, swap permitted.
REQ-015 SHALL have port rd_data, output, DATA_W: read data.
REQ-016 SHALL have port rd_valid, output, 1: rd_data valid this cycle.
REQ-017 SHALL have port front_bank, output, 1: bank currently presented to the reader.
REQ-018 SHALL have port wr_err, output, 1: sticky flag, out-of-range write seen.
REQ-019 SHALL have port swap_count, output, 8: number of swaps taken, wraps 255->0.

Function
REQ-020 SHALL store 2*NUM_WORDS words, bank b at physical index b*NUM_WORDS+addr.
REQ-021 SHALL write only to bank ~front_bank, as sampled in the cycle wr_en is high.
REQ-022 SHALL update only bytes whose wr_be bit is 1; wr_be=0 leaves the word unchanged.
REQ-023 SHALL drop writes with wr_addr >= NUM_WORDS and set wr_err next cycle.
REQ-024 SHALL present rd_data/rd_valid exactly 2 cycles after rd_en is sampled high (address register + output register); sustains one read per cycle.
REQ-025 SHALL latch the read bank together with rd_addr, so a swap inside the pipeline does not alter in-flight reads.
REQ-026 SHALL return all-zero rd_data with rd_valid=1 for rd_addr >= NUM_WORDS.
REQ-027 SHALL hold rd_data at its last value and drive rd_valid=0 when no read completes.
REQ-028 SHALL set commit_pending on the edge after commit=1; a commit while pending has no additional effect.
REQ-029 SHALL swap (toggle front_bank, clear commit_pending, increment swap_count) on the edge where (commit_pending or commit) and rd_frame_start are both 1.
REQ-030 SHALL ignore rd_frame_start when no commit is pending or presented.
REQ-031 SHALL direct a write in the swap cycle to the pre-swap back bank.
REQ-032 SHALL never read and write the same physical word in one cycle; no mixed-port read-during-write hazard exists.

Reset
REQ-033 SHALL on reset drive front_bank=0, commit_pending=0, rd_valid=0, rd_data=0, wr_err=0, swap_count=0 on the next edge.
REQ-034 SHALL flush the read pipeline on reset; reads in flight produce no rd_valid.
REQ-035 SHALL not clear memory contents on reset; contents after power-up are undefined.
REQ-036 SHALL ignore wr_en, commit and rd_en in cycles where reset=1.

Structure
REQ-037 SHALL place RD_LATENCY=2, default DATA_W/ADDR_W/NUM_WORDS, and the swap-counter width in shared package led_frame_pkg.
REQ-038 SHALL instantiate one sub-module, sdp_ram_core: parametrised simple dual-port RAM, byte-enabled write port, registered read port, no reset.
REQ-039 SHALL keep the bank-swap control, range checks and status flags in led_frame_ram.

Verification
REQ-040 SHALL cover: write 0xA5A5A5A5 @3, commit, rd_frame_start, rd_en @3 -> rd_data=0xA5A5A5A5, rd_valid 2 cycles later, front_bank=1, swap_count=1.
REQ-041 SHALL cover: word 0x11223344 then write 0xFFFFFFFF with wr_be=0b0101 -> read 0x11FF33FF after swap.
REQ-042 SHALL cover: commit with rd_frame_start held low 100 cycles -> commit_pending=1, front_bank unchanged; one rd_frame_start pulse -> exactly one swap.
REQ-043 SHALL cover: rd_en @5 in the swap cycle -> data from old front bank; rd_en next cycle -> data from new front bank.
REQ-044 SHALL cover: write @NUM_WORDS and read @NUM_WORDS -> wr_err=1 sticky, rd_data=0 with rd_valid=1, no memory word altered.
REQ-045 SHALL cover: reset asserted with 2 reads in flight and commit pending -> rd_valid never asserts, all outputs at reset values next cycle.
